// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx: 2:1 TDM bit-stream demux into two channel words with valid/ready output.
// Build option DEMUX_LSB_FIRST_EN selects LSB-first assembly (default MSB-first).
module tdm_demux_rx #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              in_sel,
  input  logic              frame_start,
  output logic [WORD_W-1:0] out0,
  output logic [WORD_W-1:0] out1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow
);
  localparam int CW = $clog2(WORD_W + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;
  localparam logic [CW-1:0] FULL = CW'(WORD_W);

  logic [0:0]        r_state;
  logic [CW-1:0]     r_cnt0, r_cnt1;
  logic [WORD_W-1:0] r_sh0, r_sh1, r_out0, r_out1;
  logic              r_out_valid, r_overflow;

  logic              w_restart, w_accept, w_take0, w_take1, w_done, w_load;
  logic [CW-1:0]     w_c0_base, w_c1_base, w_c0_nxt, w_c1_nxt;
  logic [WORD_W-1:0] w_sh0_base, w_sh1_base, w_sh0_nxt, w_sh1_nxt;

  function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] sh, input logic b);
`ifdef DEMUX_LSB_FIRST_EN
    return {b, sh[WORD_W-1:1]};
`else
    return {sh[WORD_W-2:0], b};
`endif
  endfunction

  // A frame_start beat restarts from empty words and is itself the first data bit.
  always_comb begin
    w_restart  = in_valid & frame_start;
    w_accept   = in_valid & (frame_start | (r_state == COLLECT));
    w_c0_base  = w_restart ? '0 : r_cnt0;
    w_c1_base  = w_restart ? '0 : r_cnt1;
    w_sh0_base = w_restart ? '0 : r_sh0;
    w_sh1_base = w_restart ? '0 : r_sh1;
    w_take0    = w_accept & ~in_sel & (w_c0_base != FULL);
    w_take1    = w_accept & in_sel & (w_c1_base != FULL);
    w_c0_nxt   = w_c0_base + CW'(w_take0);
    w_c1_nxt   = w_c1_base + CW'(w_take1);
    w_sh0_nxt  = w_take0 ? shift_in(w_sh0_base, in_bit) : w_sh0_base;
    w_sh1_nxt  = w_take1 ? shift_in(w_sh1_base, in_bit) : w_sh1_base;
    w_done     = w_accept & (w_c0_nxt == FULL) & (w_c1_nxt == FULL);
    w_load     = w_done & (~r_out_valid | out_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
      r_sh0       <= '0;
      r_sh1       <= '0;
      r_out0      <= '0;
      r_out1      <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_done ? IDLE : (w_restart ? COLLECT : r_state);
      r_cnt0  <= w_done ? '0 : w_c0_nxt;
      r_cnt1  <= w_done ? '0 : w_c1_nxt;
      r_sh0   <= w_done ? '0 : w_sh0_nxt;
      r_sh1   <= w_done ? '0 : w_sh1_nxt;
      if (w_load) begin
        r_out0      <= w_sh0_nxt;
        r_out1      <= w_sh1_nxt;
        r_out_valid <= 1'b1;
      end else if (r_out_valid & out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_done & ~w_load) r_overflow <= 1'b1;
    end
  end

  assign out0      = r_out0;
  assign out1      = r_out1;
  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;
endmodule

// File: tb/tb_tdm_demux_rx.sv
// tb_tdm_demux_rx: randomized and directed checks of tdm_demux_rx against a queue-based model.
module tb_tdm_demux_rx;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_bit, in_sel, frame_start, out_ready;
  logic [W-1:0] out0, out1;
  logic         out_valid, overflow;

  int errors = 0;
  int checks = 0;

  bit           m_busy, m_v, m_ov;
  bit           q0[$], q1[$];
  logic [W-1:0] m_o0, m_o1;

  tdm_demux_rx #(.WORD_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_sel(in_sel),
    .frame_start(frame_start), .out0(out0), .out1(out1), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack_word(input bit q[$]);
    logic [W-1:0] w = '0;
    for (int k = 0; k < W; k++)
`ifdef DEMUX_LSB_FIRST_EN
      w[k] = q[k];
`else
      w[W-1-k] = q[k];
`endif
    return w;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_busy = 0; m_v = 0; m_ov = 0; m_o0 = '0; m_o1 = '0;
      q0.delete(); q1.delete();
    end else begin
      bit hs = m_v & out_ready;
      if (in_valid && frame_start) begin
        q0.delete(); q1.delete(); m_busy = 1;
      end
      if (in_valid && m_busy) begin
        if (!in_sel && q0.size() < W) q0.push_back(in_bit);
        if (in_sel && q1.size() < W) q1.push_back(in_bit);
      end
      if (m_busy && q0.size() == W && q1.size() == W) begin
        m_busy = 0;
        if (!m_v || out_ready) begin
          m_o0 = pack_word(q0); m_o1 = pack_word(q1); m_v = 1;
        end else m_ov = 1;
        q0.delete(); q1.delete();
      end else if (hs) m_v = 0;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic b, input logic s,
                      input logic fs, input logic rdy);
    rst_n = r; in_valid = v; in_bit = b; in_sel = s; frame_start = fs; out_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, rdy);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  // Alternating-slot frame: ch0 bit k, then ch1 bit k, frame_start on the first beat.
  task automatic send_frame(input logic [W-1:0] b0, input logic [W-1:0] b1, input logic rdy);
    for (int k = 0; k < W; k++) begin
      step(1, 1, b0[W-1-k], 0, k == 0, rdy);
      step(1, 1, b1[W-1-k], 1, 0, rdy);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++)
      step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    checks++;
    if ({out0, out1, out_valid, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got out0=%h out1=%h v=%b ov=%b want all 0", out0, out1, out_valid, overflow);
    end
    idle(3, 1);
    checks++;
    if ({out0, out1, out_valid, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got out0=%h out1=%h v=%b ov=%b want all 0", out0, out1, out_valid, overflow);
    end
  endtask

  task automatic test_frame();
    logic [W-1:0] e0, e1;
`ifdef DEMUX_LSB_FIRST_EN
    e0 = 4'h5; e1 = 4'h6;
`else
    e0 = 4'hA; e1 = 4'h6;
`endif
    do_reset();
    for (int k = 0; k < W; k++) begin
      step(1, 1, k[0] ? 1'b0 : 1'b1, 0, k == 0, 1);
      step(1, 1, (k == 1 || k == 2), 1, 0, 1);
      if (k == W - 2) begin
        step(1, 1, 1'b0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL frame_early_valid: got %b want 0", out_valid);
        end
        step(1, 1, 1'b0, 1, 0, 1);
        break;
      end
    end
    checks++;
    if ({out0, out1, out_valid, overflow} !== {e0, e1, 2'b10}) begin
      errors++;
      $display("FAIL frame_pair: got %h %h v=%b ov=%b want %h %h v=1 ov=0", out0, out1, out_valid, overflow, e0, e1);
    end
    idle(1, 1);
    checks++;
    if (out_valid !== 1'b0 || out0 !== e0 || out1 !== e1) begin
      errors++;
      $display("FAIL frame_consume: got v=%b %h %h want v=0 %h %h", out_valid, out0, out1, e0, e1);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] a0, a1;
    do_reset();
    send_frame(4'h3, 4'hC, 0);
    a0 = m_o0; a1 = m_o1;
    send_frame(4'h9, 4'h5, 0);
    idle(2, 0);
    checks++;
    if ({out0, out1, out_valid, overflow} !== {a0, a1, 2'b11}) begin
      errors++;
      $display("FAIL ovf_hold: got %h %h v=%b ov=%b want %h %h v=1 ov=1", out0, out1, out_valid, overflow, a0, a1);
    end
    idle(1, 1);
    idle(1, 0);
    checks++;
    if ({out0, out1, out_valid, overflow} !== {a0, a1, 2'b01}) begin
      errors++;
      $display("FAIL ovf_drain: got %h %h v=%b ov=%b want %h %h v=0 ov=1", out0, out1, out_valid, overflow, a0, a1);
    end
  endtask

  task automatic test_restart();
    do_reset();
    step(1, 1, 1, 0, 1, 1);
    step(1, 1, 1, 1, 0, 1);
    step(1, 1, 1, 0, 0, 1);
    send_frame(4'h2, 4'hB, 1);
    checks++;
    if ({out0, out1, out_valid} !== {m_o0, m_o1, 1'b1} || m_o0 !== pack_word('{0, 0, 1, 0})) begin
      errors++;
      $display("FAIL restart_pair: got %h %h v=%b want %h %h v=1", out0, out1, out_valid, m_o0, m_o1);
    end
    // back-to-back: consume and complete a new pair on the same edge
    for (int k = 0; k < W; k++) begin
      step(1, 1, 1'b1, 0, k == 0, 0);
      step(1, 1, 1'b0, 1, 0, k == W - 1);
    end
    checks++;
    if ({out0, out1, out_valid, overflow} !== {4'hF, 4'h0, 2'b10}) begin
      errors++;
      $display("FAIL b2b_pair: got %h %h v=%b ov=%b want f 0 v=1 ov=0", out0, out1, out_valid, overflow);
    end
  endtask

  task automatic test_extra_ch0();
    logic [5:0] bits = 6'b100111;
    do_reset();
    for (int k = 0; k < 6; k++) step(1, 1, bits[5-k], 0, k == 0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL extra_early_valid: got %b want 0", out_valid);
    end
    for (int k = 0; k < W; k++) step(1, 1, k[0], 1, 0, 1);
    checks++;
    if ({out0, out1, out_valid} !== {pack_word('{1, 0, 0, 1}), pack_word('{0, 1, 0, 1}), 1'b1}) begin
      errors++;
      $display("FAIL extra_word: got %h %h v=%b want %h %h v=1", out0, out1, out_valid,
               pack_word('{1, 0, 0, 1}), pack_word('{0, 1, 0, 1}));
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(99) != 0, $urandom_range(3) != 0, 1'($urandom), 1'($urandom),
           $urandom_range(19) == 0, $urandom_range(2) == 0);
      checks++;
      if ({out0, out1, out_valid, overflow} !== {m_o0, m_o1, m_v, m_ov}) begin
        errors++;
        $display("FAIL random_%0d: got %h %h v=%b ov=%b want %h %h v=%b ov=%b", i,
                 out0, out1, out_valid, overflow, m_o0, m_o1, m_v, m_ov);
      end
    end
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_bit = 0; in_sel = 0; frame_start = 0; out_ready = 0;
    test_reset();
    test_frame();
    test_overflow();
    test_restart();
    test_extra_ch0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
